shared_mem_sched: RTL and testbench
===================================

Name: shared_mem_sched

Overview:
Burst-aware round-robin scheduler that time-shares the single shared scratchpad port among COUNT processors. Replaces the per-cycle grant with owner-locked bursts: a processor holds the port for consecutive beats until it signals last or deasserts its request, or hits the MAX_BURST fairness cap. Outputs a registered one-hot grant and an encoded owner index, which drive the shared memory address/data muxes directly. One instance per direction (read and write).

Parameters:
COUNT, 4, number of requesters; power of two, >= 2
MAX_BURST, 8, max consecutive beats per tenure before forced hand-off when others are waiting; >= 1
CW, $clog2(MAX_BURST+1), beat counter width (derived, not overridden)

Ports:
i_clk  input  1  clock, rising edge
i_rstn  input  1  asynchronous active-low reset
i_req  input  COUNT  per-processor request; held while the processor wants beats
i_last  input  COUNT  per-processor final-beat flag; sampled only for the current owner
o_grant  output  COUNT  registered one-hot grant; all-zero when idle
o_owner  output  $clog2(COUNT)  registered index of the granted processor; 0 when idle
o_busy  output  1  registered; high while any grant is active (equals |o_grant)
o_beat_cnt  output  CW  beats completed in the current tenure

Behaviour:
- Reset (async assert, sync release): o_grant=0, o_owner=0, o_busy=0, o_beat_cnt=0, state=IDLE, rr_ptr=0 (requester 0 has first priority).
- Beat: any cycle where o_grant[k]=1 and i_req[k]=1.
- Arbitration: search i_req starting at rr_ptr, wrapping modulo COUNT; first set bit wins. Decision is combinational; grant is registered, so first grant appears 1 cycle after the request (latency 1).
- FSM states: IDLE, OWN.
  - IDLE: if |i_req then go to OWN, o_grant=onehot(winner), o_owner=winner, o_beat_cnt=0, rr_ptr=winner+1 (mod COUNT). Otherwise stay in IDLE.
  - OWN, owner k. A release event occurs on any of:
    (a) i_req[k]=0 (abandon, no beat);
    (b) beat with i_last[k]=1;
    (c) beat making the count equal MAX_BURST while some i_req[j], j!=k, is set.
  - OWN, no release: on a beat, o_beat_cnt increments. If the count reaches MAX_BURST with no other requester, o_beat_cnt resets to 0 and k keeps ownership (no bubble).
  - OWN, on release: arbitrate in the same cycle over i_req excluding k, starting at rr_ptr. If there is a winner, hand off back-to-back with no idle cycle: new grant, o_beat_cnt=0, rr_ptr=winner+1. If there is no winner, go to IDLE with grant=0.
- Excluding the releasing owner guarantees hand-off. A requester waits at most (COUNT-1)*MAX_BURST beats plus COUNT cycles (no starvation).
- o_grant is always one-hot or zero, never multi-hot. o_grant changes only at clock edges.
- i_last on a non-owner or without i_req is ignored. A request dropped by a non-owner while waiting has no effect.
- Reset mid-burst: immediate grant removal. The in-flight beat is lost; the requester must reissue.

Optional Feature:
Macro SCHED_PRIO_EN.
- Defined: adds port i_prio input COUNT (per-requester urgent flag). Arbitration first searches the requesters with i_req&i_prio (same rr_ptr rotation). Only if that set is empty does it search plain i_req. Release rule (c) triggers when any other urgent requester is pending, or, if none, when any other requester is pending. Ownership is never pre-empted before MAX_BURST or a release.
- Not defined: no i_prio port; pure round-robin as above.

Test Plan:
- Reset with i_req=4'b1111 held -> o_grant=0 during reset. First edge after release: o_grant=4'b0001, o_owner=0. Then hand-off to 1, 2, 3, 0 every 8 beats (MAX_BURST=8).
- i_req=4'b0100 alone for 20 cycles -> o_grant=4'b0100 continuously, no bubble. o_beat_cnt runs 1..7, 0, 1..7, 0, ...
- Owner 1 asserts i_last on its 3rd beat while i_req[3]=1 -> next cycle o_grant=4'b1000, o_beat_cnt=0, no idle cycle.
- Owner 2 drops i_req with no other requests -> next cycle o_grant=0, o_busy=0. Then i_req=4'b0101 -> grant goes to 0 (rr_ptr=3 wraps past 3 to 0).
- Async reset asserted mid-burst (beat 5 of owner 3) -> o_grant=0 immediately, without waiting for a clock edge. After release with i_req=4'b1000, grant returns to 3 after 1 cycle.
- SCHED_PRIO_EN: owner 0 bursting, i_req=4'b1111, i_prio=4'b0100 -> after 8 beats grant goes to 2, not 1. Then it continues round-robin 3, 0, 1 once i_prio=0.

Source files
------------

// File: rtl/shared_mem_sched.sv
// shared_mem_sched: burst-aware round-robin owner of a single shared scratchpad port.
// Optional macro SCHED_PRIO_EN adds the i_prio urgent-request input.
module shared_mem_sched #(
    parameter int COUNT     = 4,
    parameter int MAX_BURST = 8,
    parameter int CW        = $clog2(MAX_BURST + 1)
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic [COUNT-1:0]         i_req,
    input  logic [COUNT-1:0]         i_last,
`ifdef SCHED_PRIO_EN
    input  logic [COUNT-1:0]         i_prio,
`endif
    output logic [COUNT-1:0]         o_grant,
    output logic [$clog2(COUNT)-1:0] o_owner,
    output logic                     o_busy,
    output logic [CW-1:0]            o_beat_cnt
);
    localparam int OW = $clog2(COUNT);

    typedef enum logic {IDLE, OWN} state_t;

    state_t           state_q, state_d;
    logic [COUNT-1:0] grant_q, grant_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [OW-1:0]    rr_ptr_q, rr_ptr_d;
    logic             busy_q, busy_d;
    logic [CW-1:0]    beat_cnt_q, beat_cnt_d;

    logic [COUNT-1:0] own_mask, others, cand;
    logic [CW-1:0]    cnt_inc;
    logic             beat, cap, release_ev;
    logic [OW:0]      pick;

    // Returns {found, index} of the first set bit at or after ptr, wrapping.
    function automatic logic [OW:0] rr_pick(input logic [COUNT-1:0] m,
                                            input logic [OW-1:0] ptr);
        logic [OW-1:0] idx;
        logic [OW:0]   res;
        res = '0;
        for (int unsigned i = 0; i < COUNT; i++) begin
            idx = ptr + OW'(i);
            if (!res[OW] && m[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        own_mask          = '0;
        own_mask[owner_q] = 1'b1;
        others            = i_req & ~own_mask;
        beat              = (state_q == OWN) && i_req[owner_q];
        cnt_inc           = beat_cnt_q + CW'(1);
        cap               = beat && (cnt_inc == CW'(MAX_BURST));
        release_ev        = (state_q == OWN) &&
                            (!i_req[owner_q] || (beat && i_last[owner_q]) || (cap && |others));
        // The releasing owner is excluded so a hand-off always moves on.
        cand              = (state_q == OWN) ? others : i_req;
`ifdef SCHED_PRIO_EN
        if (|(cand & i_prio)) cand = cand & i_prio;
`endif
        pick              = rr_pick(cand, rr_ptr_q);

        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        busy_d     = busy_q;
        beat_cnt_d = beat_cnt_q;

        if (state_q == IDLE || release_ev) begin
            if (pick[OW]) begin
                state_d                = OWN;
                grant_d                = '0;
                grant_d[pick[OW-1:0]]  = 1'b1;
                owner_d                = pick[OW-1:0];
                busy_d                 = 1'b1;
                beat_cnt_d             = '0;
                rr_ptr_d               = pick[OW-1:0] + OW'(1);
            end else begin
                state_d    = IDLE;
                grant_d    = '0;
                owner_d    = '0;
                busy_d     = 1'b0;
                beat_cnt_d = '0;
            end
        end else if (beat) begin
            // Lone requester at the cap wraps the count and keeps the port.
            beat_cnt_d = cap ? '0 : cnt_inc;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            busy_q     <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            busy_q     <= busy_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign o_grant    = grant_q;
    assign o_owner    = owner_q;
    assign o_busy     = busy_q;
    assign o_beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_shared_mem_sched.sv
// Scoreboard bench for shared_mem_sched: integer-level tenure model feeds an
// expectation queue that a posedge monitor drains against the DUT outputs.
module tb_shared_mem_sched;
    localparam int COUNT = 4;
    localparam int MAXB  = 8;
    localparam int CW    = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic [COUNT-1:0] req, last;
    logic [COUNT-1:0] grant;
    logic [1:0]       owner;
    logic             busy;
    logic [CW-1:0]    cnt;
`ifdef SCHED_PRIO_EN
    logic [COUNT-1:0] prio = '0;
`endif

    shared_mem_sched #(.COUNT(COUNT), .MAX_BURST(MAXB)) dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_req      (req),
        .i_last     (last),
`ifdef SCHED_PRIO_EN
        .i_prio     (prio),
`endif
        .o_grant    (grant),
        .o_owner    (owner),
        .o_busy     (busy),
        .o_beat_cnt (cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [COUNT-1:0] g;
        logic [1:0]       o;
        logic             b;
        logic [CW-1:0]    c;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference state: owner index (-1 idle), beats in tenure, next priority slot.
    int m_owner = -1;
    int m_cnt   = 0;
    int m_rr    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int rr_find(input logic [COUNT-1:0] m, input int start, input int skip);
        for (int i = 0; i < COUNT; i++) begin
            int j;
            j = (start + i) % COUNT;
            if (m[j] && j != skip) return j;
        end
        return -1;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.g = (m_owner < 0) ? '0 : COUNT'(1 << m_owner);
        e.o = (m_owner < 0) ? 2'd0 : 2'(m_owner);
        e.b = (m_owner >= 0);
        e.c = CW'(m_cnt);
        return e;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_rr    = 0;
    endtask

    task automatic model_step(input logic [COUNT-1:0] r, input logic [COUNT-1:0] l);
        int  w, skip;
        bit  rel, others;
        rel  = 0;
        skip = -1;
        if (m_owner >= 0) begin
            skip   = m_owner;
            others = (r & ~COUNT'(1 << m_owner)) != 0;
            if (!r[m_owner]) rel = 1;
            else if (l[m_owner]) rel = 1;
            else if (m_cnt + 1 == MAXB && others) rel = 1;
            else m_cnt = (m_cnt + 1 == MAXB) ? 0 : m_cnt + 1;
        end
        if (m_owner < 0 || rel) begin
            w = rr_find(r, m_rr, skip);
            m_owner = w;
            m_cnt   = 0;
            if (w >= 0) m_rr = (w + 1) % COUNT;
        end
    endtask

    task automatic cycle(input logic [COUNT-1:0] r, input logic [COUNT-1:0] l);
        @(negedge clk);
        req  = r;
        last = l;
        model_step(r, l);
        q.push_back(model_out());
    endtask

    task automatic reset_cycle(input logic [COUNT-1:0] r);
        @(negedge clk);
        req  = r;
        last = '0;
        q.push_back(model_out());
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("grant",    32'(grant), 32'(e.g));
                chk("owner",    32'(owner), 32'(e.o));
                chk("busy",     32'(busy),  32'(e.b));
                chk("beat_cnt", 32'(cnt),   32'(e.c));
            end
        end
    end

    initial begin : driver
        logic [COUNT-1:0] r;
        rstn = 1'b0;
        req  = 4'b1111;
        last = '0;
        model_reset();
        repeat (3) reset_cycle(4'b1111);

        @(negedge clk);
        rstn = 1'b1;
        model_step(4'b1111, '0);
        q.push_back(model_out());
        repeat (40) cycle(4'b1111, '0);

        repeat (2) cycle(4'b0000, '0);
        repeat (20) cycle(4'b0100, '0);

        repeat (2) cycle(4'b0000, '0);
        repeat (2) cycle(4'b0010, '0);
        cycle(4'b1010, '0);
        cycle(4'b1010, 4'b0010);
        repeat (3) cycle(4'b1000, '0);

        repeat (2) cycle(4'b0000, '0);
        repeat (3) cycle(4'b0100, '0);
        cycle(4'b0000, '0);
        repeat (3) cycle(4'b0101, '0);

        repeat (2) cycle(4'b0000, '0);
        repeat (6) cycle(4'b1000, '0);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1 chk("async_clear_grant", 32'(grant), 32'd0);
        chk("async_clear_busy", 32'(busy), 32'd0);
        model_reset();
        repeat (2) reset_cycle(4'b1000);
        @(negedge clk);
        rstn = 1'b1;
        model_step(4'b1000, '0);
        q.push_back(model_out());
        repeat (3) cycle(4'b1000, '0);

        r = '0;
        for (int n = 0; n < 800; n++) begin
            logic [COUNT-1:0] l;
            if ($urandom_range(0, 3) == 0) r = COUNT'($urandom);
            l = '0;
            for (int b = 0; b < COUNT; b++)
                if ($urandom_range(0, 7) == 0) l[b] = 1'b1;
            cycle(r, l);
        end

        repeat (2) @(posedge clk);
        #2;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
